// File: rtl/fluid_board_pkg.sv
// Shared definitions for the board-level PLL reset sequencer: state encoding,
// default timing constants and a counter-sizing helper.
package fluid_board_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Defaults assume a 50 MHz reference clock.
  localparam int unsigned DEF_PLL_RST_CYCLES = 100;    // 2 us
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE    = 1024;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width of a counter that must reach (largest limit - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fluid_board_sync2.sv
// Two-flop synchronizer for asynchronous level signals; output lags input by
// two clk edges.
module fluid_board_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses <= so both flops sample the pre-edge values;
  // blocking assignments here would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fluid_board_pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with
// bounded retries, then releases the reset of the PLL-clocked logic.
module fluid_board_pll_rst_seq
  import fluid_board_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       fail_clr,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fail,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             locked_s;

  fluid_board_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  // NOTE: every signal written below gets its hold value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        // A lock drop outranks a completing stability window.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          if (loss_q != LOSS_CNT_MAX) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAIL: begin
        if (fail_clr) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // One shared counter measures time spent in the current state.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst     <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      fail        <= (state_d == ST_FAIL);
      // High only for cycles where the registered state is and stays RUN:
      // rises one cycle after entry, drops on the edge that leaves RUN.
      sys_reset_n <= (state_q == ST_RUN) && (state_d == ST_RUN);
    end
  end

  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_fluid_board_pll_rst_seq.sv
// Scoreboard bench for fluid_board_pll_rst_seq: directed scenarios plus
// random lock traffic, each edge checked against a timer-based model.
`timescale 1ns/1ps
module tb_fluid_board_pll_rst_seq;

  localparam int unsigned P_RST   = 4;
  localparam int unsigned P_TO    = 20;
  localparam int unsigned P_STB   = 8;
  localparam int unsigned P_RETRY = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       fail_clr = 1'b0;
  logic       pll_rst, sys_reset_n, fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  fluid_board_pll_rst_seq #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .LOCK_STABLE    (P_STB),
    .MAX_RETRIES    (P_RETRY)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .fail_clr      (fail_clr),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .fail          (fail),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fail;
    logic [1:0] retry;
    logic [7:0] loss;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: phase plus a countdown of cycles left in that phase.
  // The FSM reacts to pll_locked as it was sampled two edges earlier.
  int m_phase, m_left, m_retry, m_loss;
  bit m_hist[$];

  function automatic void model_reset();
    m_phase = 0;
    m_left  = P_RST;
    m_retry = 0;
    m_loss  = 0;
    m_hist  = '{1'b0, 1'b0};
  endfunction

  function automatic void enter(input int phase, input int len);
    m_phase = phase;
    m_left  = len;
  endfunction

  function automatic obs_t model_edge(input bit locked, input bit clr);
    bit   seen;
    int   prev;
    obs_t o;
    seen = m_hist.pop_front();
    m_hist.push_back(locked);
    prev = m_phase;
    case (m_phase)
      0: if (m_left == 1) enter(1, P_TO); else m_left--;
      1: begin
        if (seen) enter(2, P_STB);
        else if (m_left == 1) begin
          if (m_retry == P_RETRY) enter(4, 0);
          else begin m_retry++; enter(0, P_RST); end
        end else m_left--;
      end
      2: begin
        if (!seen) enter(1, P_TO);
        else if (m_left == 1) begin m_retry = 0; enter(3, 0); end
        else m_left--;
      end
      3: if (!seen) begin
        if (m_loss < 255) m_loss++;
        enter(0, P_RST);
      end
      default: if (clr) begin m_retry = 0; enter(0, P_RST); end
    endcase
    o.state       = 3'(m_phase);
    o.pll_rst     = (m_phase == 0) || (m_phase == 4);
    o.sys_reset_n = (prev == 3) && (m_phase == 3);
    o.fail        = (m_phase == 4);
    o.retry       = 2'(m_retry);
    o.loss        = 8'(m_loss);
    return o;
  endfunction

  // Monitor: one expected record per clock edge, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a.state       = state;
        a.pll_rst     = pll_rst;
        a.sys_reset_n = sys_reset_n;
        a.fail        = fail;
        a.retry       = retry_cnt;
        a.loss        = lock_loss_cnt;
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cycle t=%0t: got st=%0d rst=%0b srn=%0b fail=%0b retry=%0d loss=%0d, expected st=%0d rst=%0b srn=%0b fail=%0b retry=%0d loss=%0d",
                      $time, a.state, a.pll_rst, a.sys_reset_n, a.fail, a.retry, a.loss,
                      e.state, e.pll_rst, e.sys_reset_n, e.fail, e.retry, e.loss);
      end
    end
  end

  task automatic drive_now(input bit locked, input bit clr);
    pll_locked = locked;
    fail_clr   = clr;
    exp_q.push_back(model_edge(locked, clr));
  endtask

  task automatic step(input bit locked, input bit clr);
    @(negedge clk);
    #1;
    drive_now(locked, clr);
  endtask

  // Step, then park just after the edge so DUT outputs can be observed.
  task automatic step_obs(input bit locked, input bit clr);
    step(locked, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input bit locked, input int limit, output int n);
    n = 0;
    while (state != target && n < limit) begin
      step_obs(locked, 1'b0);
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_sys_reset_n"}, sys_reset_n, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_loss"}, lock_loss_cnt, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    fail_clr   = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    drive_now(1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    model_reset();
    #25;
    check_reset_values("por");

    // Bring-up: 4-cycle PLL reset, lock 6 cycles after release.
    release_reset();
    n = 1;
    while (pll_rst && n < 50) begin step_obs(1'b0, 1'b0); n++; end
    check("bringup_pll_rst_len", n, 4);
    repeat (5) step_obs(1'b0, 1'b0);
    n = 0;
    do begin step_obs(1'b1, 1'b0); n++; end while (!sys_reset_n && n < 100);
    // First edge sampling the lock, then 11 more (2 sync + 8 stable + 1 reg).
    check("bringup_srn_latency", n, 12);
    check("bringup_state", state, 3);
    check("bringup_retry", retry_cnt, 0);
    repeat (3) step_obs(1'b1, 1'b0);

    // Lock loss in RUN.
    n = 0;
    do begin step_obs(1'b0, 1'b0); n++; end while (sys_reset_n && n < 10);
    check("loss_srn_latency", n, 3);
    check("loss_cnt_first", lock_loss_cnt, 1);
    check("loss_pll_rst_rise", pll_rst, 1);
    n = 0;
    while (pll_rst && n < 50) begin step_obs(1'b0, 1'b0); n++; end
    check("loss_pll_rst_len", n, 4);

    // Lock glitch in STABLE at count 5 restarts the stability window.
    wait_state(3'd2, 1'b1, 100, n);
    repeat (3) step_obs(1'b1, 1'b0);
    repeat (3) step_obs(1'b0, 1'b0);
    check("glitch_state", state, 1);
    check("glitch_retry", retry_cnt, 0);
    wait_state(3'd3, 1'b1, 100, n);
    check("glitch_relock_len", n, 11);

    // Loss coinciding with the last stable count.
    repeat (3) step_obs(1'b0, 1'b0);
    wait_state(3'd2, 1'b1, 100, n);
    repeat (5) step_obs(1'b1, 1'b0);
    repeat (3) step_obs(1'b0, 1'b0);
    check("tie_loss_wins", state, 1);

    // Asynchronous reset from RUN.
    wait_state(3'd3, 1'b1, 100, n);
    step_obs(1'b1, 1'b0);
    check("pre_reset_run", sys_reset_n, 1);
    async_reset();

    // No lock: three attempts, then FAIL until cleared.
    release_reset();
    n = 1;
    while (!fail && n < 300) begin step_obs(1'b0, 1'b0); n++; end
    check("fail_entry_cycles", n, 72);
    check("fail_state", state, 4);
    check("fail_retry", retry_cnt, 2);
    check("fail_pll_rst", pll_rst, 1);
    repeat (3) step_obs(1'b0, 1'b0);
    check("fail_held", fail, 1);
    step_obs(1'b0, 1'b1);
    check("fail_clr_state", state, 0);
    check("fail_clr_retry", retry_cnt, 0);
    check("fail_clr_fail", fail, 0);

    // 256 lock losses saturate the loss counter.
    for (int i = 0; i < 256; i++) begin
      wait_state(3'd3, 1'b1, 100, n);
      step_obs(1'b0, 1'b0);
      step_obs(1'b1, 1'b0);
      step_obs(1'b1, 1'b0);
    end
    check("loss_cnt_saturated", lock_loss_cnt, 255);

    // Random lock traffic with stray fail_clr pulses.
    for (int seg = 0; seg < 200; seg++) begin
      bit lk;
      int len;
      lk  = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 30);
      if (!lk && $urandom_range(0, 5) == 0) len = $urandom_range(60, 120);
      for (int k = 0; k < len; k++) step(lk, ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fluid_board_pll_rst_seq.md
FLUID_BOARD_PLL_RST_SEQ -- requirements
Module: fluid_board_pll_rst_seq

Interface
REQ-001 Parameter: PLL_RST_CYCLES, 100, cycles pll_rst is held high per reset attempt (2 us at 50 MHz).
REQ-002 Parameter: LOCK_TIMEOUT, 50000, cycles allowed for lock after pll_rst release (1 ms).
REQ-003 Parameter: LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before sys_reset_n release.
REQ-004 Parameter: MAX_RETRIES, 3, PLL reset retries after the first attempt before FAIL.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-006 Port: clk  in  1  free-running 50 MHz board reference clock, the same clock that feeds the PLL refclk.
REQ-007 Port: reset_n  in  1  asynchronous active-low reset.
REQ-008 Port: pll_locked  in  1  PLL locked output, asynchronous to clk.
REQ-009 Port: fail_clr  in  1  single-cycle pulse; leaves FAIL.
REQ-010 Port: pll_rst  out  1  active-high PLL reset, drives PLL rst.
REQ-011 Port: sys_reset_n  out  1  active-low reset for logic clocked by PLL outputs.
REQ-012 Port: fail  out  1  high while in FAIL.
REQ-013 Port: state  out  3  current state encoding.
REQ-014 Port: retry_cnt  out  2  retries used in the current lock sequence.
REQ-015 Port: lock_loss_cnt  out  8  saturating count of lock losses in RUN.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); latency 2 cycles.
REQ-017 States SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; a single shared counter is cleared on every state change.
REQ-018 PLL_RST: pll_rst=1; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; on count reaching LOCK_TIMEOUT-1 with locked_s=0 -> FAIL if retry_cnt==MAX_RETRIES, else retry_cnt+1 and -> PLL_RST.
REQ-020 STABLE: locked_s=0 -> WAIT_LOCK with timeout restarted and retry_cnt unchanged; on count reaching LOCK_STABLE-1 with locked_s=1 -> RUN and retry_cnt cleared.
REQ-021 RUN: locked_s=0 -> PLL_RST and lock_loss_cnt increments, saturating at 255.
REQ-022 FAIL: pll_rst=1 and fail=1 are held; fail_clr=1 -> PLL_RST with retry_cnt cleared; fail_clr is ignored in all other states.
REQ-023 All outputs SHALL be registered; sys_reset_n=1 only while registered state==RUN, so it rises one cycle after entry to RUN and falls on the edge that leaves RUN.
REQ-024 When locked_s falls in the same cycle a STABLE count completes, the loss SHALL win (-> WAIT_LOCK).
REQ-025 The state register SHALL recover to PLL_RST from any illegal encoding (5-7).

Reset
REQ-026 With reset_n low (asynchronously): state=PLL_RST, pll_rst=1, sys_reset_n=0, fail=0, retry_cnt=0, lock_loss_cnt=0, counter=0, synchronizer flops=0.
REQ-027 reset_n assertion mid-operation SHALL drive sys_reset_n low and pll_rst high without waiting for a clock edge.

Structure
REQ-028 State encoding and the default parameter constants SHALL live in shared package fluid_board_pkg.
REQ-029 The synchronizer SHALL be sub-module fluid_board_sync2 (width-parameterized, async active-low reset).

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-030 reset_n released, pll_locked rises 6 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; sys_reset_n rises 11 cycles after pll_locked (2 sync + 8 stable + 1 register); retry_cnt=0.
REQ-031 pll_locked held 0 -> three 4-cycle pll_rst pulses separated by 20-cycle waits, then fail=1, pll_rst=1, retry_cnt=2, state=4; a fail_clr pulse -> state=0, retry_cnt=0.
REQ-032 pll_locked drops for 3 cycles at stable count 5 -> state returns to 1, retry_cnt unchanged, and a full 8 stable cycles are required after relock.
REQ-033 pll_locked falls in RUN -> sys_reset_n low within 3 cycles, lock_loss_cnt 0->1, new 4-cycle pll_rst pulse; 256 losses leave lock_loss_cnt=255.
REQ-034 reset_n asserted mid-RUN -> sys_reset_n=0 and pll_rst=1 with no clock edge, and all counters are zero.
